// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue controller and its command FIFO.
// The optional SHIFT_ISSUE_STATS_EN build only affects shift_issue_ctrl.
package shift_pkg;

    localparam int   SHIFT_W   = 8;
    localparam int   AMT_W     = 3;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic [AMT_W-1:0]   amt;
        logic               dir;
    } shift_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO for shift_issue_ctrl; occupancy counter separates full from empty.
// Storage is not reset; only pointers and count are.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  shift_cmd_t wdata,
    output shift_cmd_t rdata,
    output logic       full,
    output logic       empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    shift_cmd_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/shift_issue_ctrl.sv
// Front-end for the 8-bit barrel shifter: queues commands, drives the shifter from registers
// and registers its result into a back-pressurable stream. SHIFT_ISSUE_STATS_EN adds counters.
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] in_data,
    input  logic [AMT_W-1:0]   in_amt,
    input  logic               in_dir,
    output logic [SHIFT_W-1:0] shf_d,
    output logic [AMT_W-1:0]   shf_s,
    output logic               shf_c,
    input  logic [SHIFT_W-1:0] shf_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_data
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    output logic [15:0]        stat_done,
    output logic [15:0]        stat_stall
`endif
);

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shf_d_q, shf_d_d;
    logic [AMT_W-1:0]   shf_s_q, shf_s_d;
    logic               shf_c_q, shf_c_d;
    logic               out_valid_q, out_valid_d;
    logic [SHIFT_W-1:0] out_data_q, out_data_d;

    shift_cmd_t         fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic               slot_free;

    assign fifo_wdata = '{data: in_data, amt: in_amt, dir: in_dir};
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign slot_free  = !out_valid_q || out_ready;

    shift_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        shf_d_d     = shf_d_q;
        shf_s_d     = shf_s_q;
        shf_c_d     = shf_c_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shf_d_d = fifo_rdata.data;
                    shf_s_d = fifo_rdata.amt;
                    shf_c_d = fifo_rdata.dir;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Capture the shifter result and immediately issue the next command if queued.
                if (slot_free) begin
                    out_data_d  = shf_out;
                    out_valid_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shf_d_d = fifo_rdata.data;
                        shf_s_d = fifo_rdata.amt;
                        shf_c_d = fifo_rdata.dir;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shf_d_q     <= '0;
            shf_s_q     <= '0;
            shf_c_q     <= DIR_LEFT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shf_d_q     <= shf_d_d;
            shf_s_q     <= shf_s_d;
            shf_c_q     <= shf_c_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign shf_d     = shf_d_q;
    assign shf_s     = shf_s_q;
    assign shf_c     = shf_c_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Handoff count wraps; stall count saturates.
    always_comb begin
        stat_done_d  = stat_done_q;
        stat_stall_d = stat_stall_q;
        if (out_valid_q && out_ready) begin
            stat_done_d = stat_done_q + 16'd1;
        end
        if ((state_q == EXEC) && !slot_free && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_done_q  <= stat_done_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_done  = stat_done_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl with a behavioural barrel shifter attached.
// Counter checks are built only when SHIFT_ISSUE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_shift_issue_ctrl;
    import shift_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic       in_dir = 1'b0;
    logic [7:0] shf_d;
    logic [2:0] shf_s;
    logic       shf_c;
    logic [7:0] shf_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign shf_out = (shf_c == DIR_RIGHT) ? (shf_d >> shf_s) : (shf_d << shf_s);

    shift_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .shf_d     (shf_d),
        .shf_s     (shf_s),
        .shf_c     (shf_c),
        .shf_out   (shf_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFT_ISSUE_STATS_EN
        ,
        .stat_done (stat_done),
        .stat_stall(stat_stall)
`endif
    );

    task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic dir);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if ({shf_d, shf_s, shf_c} !== 12'h000) begin errors++; $display("FAIL reset_shf: got %h/%h/%b expected 0/0/0", shf_d, shf_s, shf_c); end
    endtask

    task automatic test_single(input logic [7:0] d, input logic [2:0] a, input logic dir, input logic [7:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
        drive(d, a, dir);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_e0: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_e1: got %b expected 0", out_valid); end
        checks++; if ({shf_d, shf_s, shf_c} !== {d, a, dir}) begin errors++; $display("FAIL single_shf_load: got %h/%h/%b expected %h/%h/%b", shf_d, shf_s, shf_c, d, a, dir); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", out_data, exp); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sd [0:7];
        logic [2:0] sa [0:7];
        logic       sr [0:7];
        logic [7:0] se [0:7];
        sd = '{8'h81, 8'h81, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3};
        sa = '{3'd1,  3'd1,  3'd4,  3'd4,  3'd7,  3'd7,  3'd0,  3'd2};
        sr = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        se = '{8'h02, 8'h40, 8'hF0, 8'h0F, 8'h80, 8'h01, 8'h5A, 8'h30};
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c >= 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== se[c-3]) begin errors++; $display("FAIL b2b_result%0d: got v=%b d=%h expected v=1 d=%h", c-3, out_valid, out_data, se[c-3]); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early%0d: got %b expected 0", c, out_valid); end
            end
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", c, in_ready); end
                drive(sd[c], sa[c], sr[c]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bd [0:5];
        logic [2:0] ba [0:5];
        logic       br [0:5];
        logic [7:0] be [0:5];
        int n;
        int k;
        bd = '{8'h0F, 8'hF0, 8'h33, 8'h33, 8'h96, 8'h01};
        ba = '{3'd4,  3'd4,  3'd1,  3'd1,  3'd0,  3'd3};
        br = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        be = '{8'hF0, 8'h0F, 8'h66, 8'h19, 8'h96, 8'h08};
        @(negedge clk);
        out_ready = 1'b0;
        drive(bd[0], ba[0], br[0]);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1 within 10 cycles", out_valid); end
        for (int i = 1; i <= DEPTH + 1; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_accept%0d: got %b expected 1", i, in_ready); end
            drive(bd[i], ba[i], br[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== be[0]) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, be[0]); end
        end
        out_ready = 1'b1;
        k = 0;
        n = 0;
        while (k < DEPTH + 2 && n < 20) begin
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== be[k]) begin errors++; $display("FAIL bp_drain%0d: got %h expected %h", k, out_data, be[k]); end
                k++;
            end
            @(negedge clk);
            n++;
        end
        checks++; if (k !== DEPTH + 2) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", k, DEPTH + 2); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready%0d: got %b expected 1", i, in_ready); end
            drive(8'h10 + 8'(i), 3'd1, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rstmid_out: got v=%b d=%h expected v=0 d=00", out_valid, out_data); end
        checks++; if ({shf_d, shf_s, shf_c} !== 12'h000) begin errors++; $display("FAIL rstmid_shf: got %h/%h/%b expected 0/0/0", shf_d, shf_s, shf_c); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got %b expected 0", i, out_valid); end
        end
        test_single(8'hB5, 3'd3, 1'b0, 8'hA8);
    endtask

`ifdef SHIFT_ISSUE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (stat_done !== 16'd0 || stat_stall !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_done, stat_stall); end
        drive(8'h01, 3'd1, 1'b0);
        @(negedge clk);
        drive(8'h02, 3'd1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (stat_stall !== 16'd3) begin errors++; $display("FAIL stats_stall3: got %0d expected 3", stat_stall); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(8'h40, 3'd2, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
        end
        checks++; if (stat_done !== 16'd5) begin errors++; $display("FAIL stats_done5: got %0d expected 5", stat_done); end
        checks++; if (stat_stall !== 16'd3) begin errors++; $display("FAIL stats_stall_hold: got %0d expected 3", stat_stall); end
        drive(8'h55, 3'd1, 1'b0);
        for (int i = 0; i < 65530; i++) begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (stat_done !== 16'hFFFF) begin errors++; $display("FAIL stats_done_max: got %h expected ffff", stat_done); end
        drive(8'h55, 3'd1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (stat_done !== 16'h0000) begin errors++; $display("FAIL stats_done_wrap: got %h expected 0000", stat_done); end
    endtask
`endif

    initial begin
        test_reset();
        test_single(8'hB5, 3'd3, 1'b0, 8'hA8);
        test_single(8'hB5, 3'd2, 1'b1, 8'h2D);
        test_single(8'h3C, 3'd0, 1'b1, 8'h3C);
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef SHIFT_ISSUE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_issue_ctrl.md
Name: shift_issue_ctrl

Overview:
- Sequential front-end for the team's 8-bit combinational left/right barrel shifter.
- Accepts shift commands (data, 3-bit amount, direction) over a valid/ready stream and buffers them in a small FIFO.
- Drives the shifter inputs from registers and captures the shifter output into a registered, back-pressurable result stream.
- Sits directly upstream of the shifter instance, and the shifter's output feeds straight back into it.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command offered.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_data  input  8  operand.
- in_amt  input  3  shift amount 0..7.
- in_dir  input  1  0 = left, 1 = right (matches shifter c).
- shf_d  output  8  registered operand to shifter d.
- shf_s  output  3  registered amount to shifter s.
- shf_c  output  1  registered direction to shifter c.
- shf_out  input  8  shifter result (combinational from shf_*).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8  registered result.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - FIFO is empty and pointers are 0; state = IDLE.
  - shf_d = 0, shf_s = 0, shf_c = 0.
  - out_valid = 0, out_data = 0.
  - in_ready is 1 after reset.
- Reset mid-operation discards all queued and in-flight commands. No result is emitted for them.
- FIFO:
  - in_ready = !full. The full flag is not relaxed by a same-cycle pop.
  - Push on in_valid && in_ready.
  - Push and pop may occur in the same cycle. Occupancy is then unchanged.
  - A pop from an empty FIFO never happens.
  - Pointers wrap modulo DEPTH. Full/empty are distinguished by an occupancy count of width PTR_W+1.
- FSM, states IDLE and EXEC:
  - IDLE: if FIFO non-empty, pop, load shf_* from the head entry, go to EXEC. Otherwise stay.
  - EXEC: shf_* hold a valid command. The slot is free when !out_valid || out_ready.
    - Slot free: out_data <= shf_out and out_valid <= 1. Then, if FIFO non-empty, pop and load the next command into shf_* (stay in EXEC); else go to IDLE (shf_* keep their last value).
    - Slot not free: stall. shf_* and out_data hold, no pop.
  - In IDLE with out_valid && out_ready: out_valid <= 0.
- Latency: a command accepted at edge E yields out_valid at edge E+2 when the FIFO is empty and the output is free.
- Throughput: 1 result per cycle when streaming without backpressure.
- Output: out_data is stable while out_valid && !out_ready.
- Ordering: results appear strictly in command order; no drops, no duplicates.
- Amount 0: result = operand; passed through like any other command.

Optional Feature:
- Macro: SHIFT_ISSUE_STATS_EN.
- Defined:
  - Adds output stat_done [15:0]: count of results handed off (out_valid && out_ready). Wraps at 16'hFFFF -> 0.
  - Adds output stat_stall [15:0]: count of cycles in EXEC with the slot not free. Saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - typedef shift_cmd_t {data[7:0], amt[2:0], dir}, 12 bits.
  - localparams SHIFT_W = 8, AMT_W = 3, DIR_LEFT = 0, DIR_RIGHT = 1.
  - FSM state enum {IDLE, EXEC}.
- One sub-module: shift_cmd_fifo, a synchronous FIFO of shift_cmd_t with DEPTH entries exposing full, empty, push and pop. The FSM and output register stay in shift_issue_ctrl.

Test Plan:
- Single command, bench shifter attached: d = 8'hB5, amt = 3, dir = 0 -> out_data = 8'hA8, out_valid at accept + 2 cycles.
- Right shift: d = 8'hB5, amt = 2, dir = 1 -> 8'h2D. Amount 0: d = 8'h3C, dir = 1 -> 8'h3C.
- Stream of 8 back-to-back commands with out_ready = 1 -> 8 results on consecutive cycles, in order; in_ready never drops.
- Hold out_ready = 0, push DEPTH+2 commands:
  - in_ready falls after exactly DEPTH+1 accepts (DEPTH queued, 1 in shf_*).
  - out_data stays constant while held.
  - Release out_ready -> all DEPTH+2 results drain in order.
- Assert rst for 1 cycle with 3 commands queued and out_valid = 1 -> out_valid = 0, out_data = 0, shf_* = 0, in_ready = 1 immediately; no stale results afterwards.
- With SHIFT_ISSUE_STATS_EN: 5 handoffs and 3 stall cycles -> stat_done = 5, stat_stall = 3. Preload stat_done = 16'hFFFF, one more handoff -> 0.
